// File: rtl/packet_receiver.sv
// Write-side ingress of the per-port path: stages packet bytes into the fifo row
// and commits a well-formed packet with a single winc pulse on its crc word.
module packet_receiver #(
   parameter int UWIDTH    = 8,
   parameter int PTR_IN_SZ = 4,
   parameter int MAX_DSZ   = 7
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 packet_valid_in,
   input  logic [UWIDTH-1:0]    packet_in,
   input  logic                 wfull,
   output logic                 winc,
   output logic [PTR_IN_SZ-1:0] waddr_in,
   output logic [UWIDTH-1:0]    wdata,
   output logic                 crc_err,
   output logic                 size_err,
   output logic                 frag_err,
   output logic                 ovf_err
);

   // state | meaning
   // IDLE  | waiting for source_id (or catching an overlong byte after crc)
   // DEST  | expecting dest_id
   // SIZE  | expecting size, range-checked against MAX_DSZ
   // DATA  | collecting dsz data bytes
   // CRC   | expecting crc, commit decision
   // DROP  | discarding the rest of a rejected packet
   typedef enum logic [2:0] {
      S_IDLE, S_DEST, S_SIZE, S_DATA, S_CRC, S_DROP
   } state_t;

   localparam int CW = $clog2(MAX_DSZ + 1);

   state_t                 state, state_nxt;
   logic [UWIDTH-1:0]      acc, acc_nxt;
   logic [CW-1:0]          dsz, dsz_nxt;
   logic [CW-1:0]          dcnt, dcnt_nxt;
   logic [CW-1:0]          dcnt_inc;
   logic                   last_crc, last_crc_nxt;
   logic                   winc_nxt, crc_err_nxt, size_err_nxt, frag_err_nxt, ovf_err_nxt;
   logic [PTR_IN_SZ-1:0]   waddr_nxt;
   logic [UWIDTH-1:0]      wdata_nxt;

   assign dcnt_inc = dcnt + CW'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         acc      <= '0;
         dsz      <= '0;
         dcnt     <= '0;
         last_crc <= 1'b0;
         winc     <= 1'b0;
         waddr_in <= '0;
         wdata    <= '0;
         crc_err  <= 1'b0;
         size_err <= 1'b0;
         frag_err <= 1'b0;
         ovf_err  <= 1'b0;
      end else begin
         state    <= state_nxt;
         acc      <= acc_nxt;
         dsz      <= dsz_nxt;
         dcnt     <= dcnt_nxt;
         last_crc <= last_crc_nxt;
         winc     <= winc_nxt;
         waddr_in <= waddr_nxt;
         wdata    <= wdata_nxt;
         crc_err  <= crc_err_nxt;
         size_err <= size_err_nxt;
         frag_err <= frag_err_nxt;
         ovf_err  <= ovf_err_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      acc_nxt      = acc;
      dsz_nxt      = dsz;
      dcnt_nxt     = dcnt;
      last_crc_nxt = 1'b0;
      winc_nxt     = 1'b0;
      crc_err_nxt  = 1'b0;
      size_err_nxt = 1'b0;
      frag_err_nxt = 1'b0;
      ovf_err_nxt  = 1'b0;
      waddr_nxt    = waddr_in;
      wdata_nxt    = wdata;

      case (state)
         S_IDLE: begin
            if (packet_valid_in) begin
               // a byte right after the crc means the previous packet ran long
               if (last_crc) begin
                  frag_err_nxt = 1'b1;
                  state_nxt    = S_DROP;
               end else if (wfull) begin
                  ovf_err_nxt = 1'b1;
                  state_nxt   = S_DROP;
               end else begin
                  waddr_nxt = '0;
                  wdata_nxt = packet_in;
                  acc_nxt   = packet_in;
                  state_nxt = S_DEST;
               end
            end
         end
         S_DEST: begin
            if (packet_valid_in) begin
               waddr_nxt = PTR_IN_SZ'(1);
               wdata_nxt = packet_in;
               acc_nxt   = acc ^ packet_in;
               state_nxt = S_SIZE;
            end else begin
               frag_err_nxt = 1'b1;
               state_nxt    = S_IDLE;
            end
         end
         S_SIZE: begin
            if (packet_valid_in) begin
               if (packet_in >= UWIDTH'(1) && packet_in <= UWIDTH'(MAX_DSZ)) begin
                  waddr_nxt = PTR_IN_SZ'(2);
                  wdata_nxt = packet_in;
                  acc_nxt   = acc ^ packet_in;
                  dsz_nxt   = packet_in[CW-1:0];
                  dcnt_nxt  = '0;
                  state_nxt = S_DATA;
               end else begin
                  size_err_nxt = 1'b1;
                  state_nxt    = S_DROP;
               end
            end else begin
               frag_err_nxt = 1'b1;
               state_nxt    = S_IDLE;
            end
         end
         S_DATA: begin
            if (packet_valid_in) begin
               waddr_nxt = PTR_IN_SZ'(3) + PTR_IN_SZ'(dcnt);
               wdata_nxt = packet_in;
               acc_nxt   = acc ^ packet_in;
               dcnt_nxt  = dcnt_inc;
               if (dcnt_inc == dsz) state_nxt = S_CRC;
            end else begin
               frag_err_nxt = 1'b1;
               state_nxt    = S_IDLE;
            end
         end
         S_CRC: begin
            if (packet_valid_in) begin
               waddr_nxt    = PTR_IN_SZ'(3) + PTR_IN_SZ'(dsz);
               wdata_nxt    = packet_in;
               last_crc_nxt = 1'b1;
               if (packet_in != acc)  crc_err_nxt = 1'b1;
               else if (wfull)        ovf_err_nxt = 1'b1;
               else                   winc_nxt    = 1'b1;
            end else begin
               frag_err_nxt = 1'b1;
            end
            state_nxt = S_IDLE;
         end
         S_DROP: begin
            if (!packet_valid_in) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_packet_receiver.sv
// Directed bench for packet_receiver: staging, commit, error pulses, reset, spacing.
module tb_packet_receiver;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       packet_valid_in = 1'b0;
   logic [7:0] packet_in = 8'd0;
   logic       wfull = 1'b0;
   logic       winc;
   logic [3:0] waddr_in;
   logic [7:0] wdata;
   logic       crc_err, size_err, frag_err, ovf_err;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int winc_cyc [2];

   logic [7:0] good_pkt [7];
   logic [7:0] badcrc_pkt [7];

   packet_receiver #(.UWIDTH(8), .PTR_IN_SZ(4), .MAX_DSZ(7)) dut (
      .clk             (clk),
      .rst             (rst),
      .packet_valid_in (packet_valid_in),
      .packet_in       (packet_in),
      .wfull           (wfull),
      .winc            (winc),
      .waddr_in        (waddr_in),
      .wdata           (wdata),
      .crc_err         (crc_err),
      .size_err        (size_err),
      .frag_err        (frag_err),
      .ovf_err         (ovf_err)
   );

   always #5 clk = ~clk;

   task automatic step(input logic v, input logic [7:0] b, input logic f);
      @(negedge clk);
      packet_valid_in = v;
      packet_in       = b;
      wfull           = f;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_pulses(input string tag, input logic w, input logic ce,
                             input logic se, input logic fe, input logic oe);
      chk({tag, ".winc"},     32'(winc),     32'(w));
      chk({tag, ".crc_err"},  32'(crc_err),  32'(ce));
      chk({tag, ".size_err"}, 32'(size_err), 32'(se));
      chk({tag, ".frag_err"}, 32'(frag_err), 32'(fe));
      chk({tag, ".ovf_err"},  32'(ovf_err),  32'(oe));
   endtask

   task automatic chk_stage(input string tag, input int a, input logic [7:0] d);
      chk({tag, ".waddr_in"}, 32'(waddr_in), 32'(a));
      chk({tag, ".wdata"},    32'(wdata),    32'(d));
   endtask

   // Sends a 7-word size-3 packet; wfull is raised only on the crc byte when fcrc is set.
   task automatic send_pkt(input string tag, input logic [7:0] b [7], input logic fcrc,
                           input logic w, input logic ce, input logic oe, input int slot);
      for (int i = 0; i < 7; i++) begin
         step(1'b1, b[i], (i == 6) ? fcrc : 1'b0);
         chk_stage($sformatf("%s.w%0d", tag, i), i, b[i]);
         if (i < 6) chk_pulses($sformatf("%s.w%0d", tag, i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         else       chk_pulses($sformatf("%s.w%0d", tag, i), w, ce, 1'b0, 1'b0, oe);
         if (winc === 1'b1 && slot >= 0) winc_cyc[slot] = cyc;
      end
   endtask

   task automatic idle(input string tag);
      step(1'b0, 8'd0, 1'b0);
      chk_pulses(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      // 10^160^3^0^1^2 = 170
      good_pkt   = '{8'd10, 8'd160, 8'd3, 8'd0, 8'd1, 8'd2, 8'd170};
      badcrc_pkt = '{8'd10, 8'd160, 8'd3, 8'd0, 8'd1, 8'd2, 8'd15};

      rst = 1'b1;
      step(1'b0, 8'd0, 1'b0);
      step(1'b0, 8'd0, 1'b0);
      chk_pulses("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk_stage("reset", 0, 8'd0);
      rst = 1'b0;
      idle("reset_rel");

      send_pkt("good", good_pkt, 1'b0, 1'b1, 1'b0, 1'b0, -1);
      idle("good_gap");

      send_pkt("badcrc", badcrc_pkt, 1'b0, 1'b0, 1'b1, 1'b0, -1);
      idle("badcrc_gap");

      // size 0: words 0,1 staged, then rejected and the tail dropped
      step(1'b1, 8'd1, 1'b0); chk_stage("sz0.w0", 0, 8'd1);
      step(1'b1, 8'd2, 1'b0); chk_stage("sz0.w1", 1, 8'd2);
      step(1'b1, 8'd0, 1'b0); chk_pulses("sz0.size", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 8'(i + 5), 1'b0);
         chk_pulses($sformatf("sz0.drop%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      idle("sz0_gap");

      step(1'b1, 8'd1, 1'b0);
      step(1'b1, 8'd2, 1'b0);
      step(1'b1, 8'd8, 1'b0); chk_pulses("sz8.size", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 9; i++) begin
         step(1'b1, 8'(i), 1'b0);
         chk_pulses($sformatf("sz8.drop%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      idle("sz8_gap");
      send_pkt("after_sz", good_pkt, 1'b0, 1'b1, 1'b0, 1'b0, -1);
      idle("after_sz_gap");

      // truncated after data byte 2 of 3
      for (int i = 0; i < 5; i++) step(1'b1, good_pkt[i], 1'b0);
      chk_stage("trunc.w4", 4, 8'd1);
      step(1'b0, 8'd0, 1'b0);
      chk_pulses("trunc", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle("trunc_gap");
      send_pkt("after_trunc", good_pkt, 1'b0, 1'b1, 1'b0, 1'b0, -1);
      idle("after_trunc_gap");

      // fifo full at source byte: whole packet dropped
      step(1'b1, 8'd10, 1'b1);
      chk_pulses("full_src", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 1; i < 7; i++) begin
         step(1'b1, good_pkt[i], 1'b0);
         chk_pulses($sformatf("full_src.drop%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      idle("full_src_gap");

      send_pkt("full_crc", good_pkt, 1'b1, 1'b0, 1'b0, 1'b1, -1);
      idle("full_crc_gap");

      // overlong: a byte directly after the crc byte
      send_pkt("ovl", good_pkt, 1'b0, 1'b1, 1'b0, 1'b0, -1);
      step(1'b1, 8'd99, 1'b0);
      chk_pulses("ovl.extra", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle("ovl_gap");

      // reset at data byte 1
      for (int i = 0; i < 4; i++) step(1'b1, good_pkt[i], 1'b0);
      rst = 1'b1;
      step(1'b1, 8'd1, 1'b0);
      chk_pulses("rst_mid", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk_stage("rst_mid", 0, 8'd0);
      rst = 1'b0;
      idle("rst_mid_after");
      idle("rst_mid_after2");

      // back-to-back with one idle cycle between
      send_pkt("b2b0", good_pkt, 1'b0, 1'b1, 1'b0, 1'b0, 0);
      idle("b2b_gap");
      send_pkt("b2b1", good_pkt, 1'b0, 1'b1, 1'b0, 1'b0, 1);
      chk("b2b.spacing", 32'(winc_cyc[1] - winc_cyc[0]), 32'd8);
      idle("b2b_end");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
